uart_sel_ctrl: RTL and testbench
================================

Name: uart_sel_ctrl

Overview:
- Generates the s0/s1 port-select pair that drives the UART selector, which routes host tx2/rx2 to one of four UART ports.
- Raw board switches are synchronized and debounced.
- A new selection is committed only after both host-side lines have been idle (high) for a full frame time, so a character in flight is never cut or misrouted.
- Sits directly upstream of the selector; its s0/s1 outputs connect straight to the selector's s0/s1 inputs.

Parameters:
DEBOUNCE_CYCLES, 270000, consecutive cycles a switch value must hold before acceptance (10 ms at 27 MHz)
IDLE_CYCLES, 28125, consecutive cycles both lines must be high before a switch-over (one 10-bit frame at 9600 baud, 27 MHz)

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
sw0  input  1  raw select switch bit 0, asynchronous, bouncy
sw1  input  1  raw select switch bit 1, asynchronous, bouncy
tx_line  input  1  host transmit line (tx2), asynchronous; 1 = idle
rx_line  input  1  selected-port receive line (rx2), asynchronous; 1 = idle; board pull-up, so any non-1 sample counts as busy
s0  output  1  committed select bit 0, registered
s1  output  1  committed select bit 1, registered
pending  output  1  high while a debounced selection differs from the committed one
switched  output  1  one-cycle pulse in the cycle after s1/s0 change

Behaviour:
- One clock (clk). Reset is synchronous and active-high: all state below loads its reset value on the clk edge where reset=1.
- Reset values:
  - s1/s0 = 00; pending = 0; switched = 0.
  - Debounced select = 00; debounce counter = 0; idle counter = 0.
  - Switch synchronizer flops = 0; line synchronizer flops = 1.
  - FSM = ACTIVE.
- Synchronizers: two-flop on each of sw0, sw1, tx_line, rx_line. Downstream logic uses only the second-stage outputs.
- Debounce:
  - A candidate register holds the synced {sw1,sw0}.
  - If the synced value != candidate: candidate <= synced value, counter <= 0.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES-1.
  - The debounced select loads the candidate on the cycle the counter equals DEBOUNCE_CYCLES-1.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count. A bit-level bounce on only one switch also restarts it.
- Idle monitor:
  - Idle counter clears to 0 on any cycle either synced line = 0.
  - Otherwise it increments, saturating at IDLE_CYCLES.
  - line_idle = (counter == IDLE_CYCLES).
- FSM, states ACTIVE, PENDING, SWITCH:
  - ACTIVE: if debounced != {s1,s0}, go to PENDING.
  - PENDING: if debounced == {s1,s0} (user reverted), go to ACTIVE with no output change. Else if line_idle, go to SWITCH.
  - SWITCH: {s1,s0} <= debounced; go to ACTIVE. switched is high in the following cycle for exactly 1 cycle.
  - Debounced value changing while PENDING (e.g. 01→10): the latest debounced value is the one committed in SWITCH.
  - pending = 1 in PENDING and SWITCH, else 0.
- Latency with lines already idle-saturated: s1/s0 change within DEBOUNCE_CYCLES+3 to DEBOUNCE_CYCLES+6 cycles after the raw switch settles.
- Line activity:
  - Continuous line activity (counter never saturates) holds PENDING indefinitely; s1/s0 stay unchanged.
  - A line going low in the same cycle line_idle would first assert blocks the switch: the counter clears first.
- s1/s0 never take a value other than a debounced value.
- s1/s0 never change more than once per IDLE_CYCLES+1 cycles unless reset intervenes.
- Reset mid-PENDING: discards the pending request; s1/s0 return to 00.
  - If switches still read non-00, the full debounce and idle sequence reruns after reset.
- Power-up with switches at 11: reaches s1/s0 = 11 only after debounce plus idle time.

Test Plan:
(All with DEBOUNCE_CYCLES=8, IDLE_CYCLES=20.)
- Reset, lines high, switches set to {sw1,sw0}=10 and held → pending rises about 11 cycles later; s1/s0 = 10 within 17 cycles of the change; switched pulses once; pending then 0.
- Lines high, sw0 toggles every 3 cycles for 40 cycles then settles 0 → s1/s0 stay 00 throughout; pending never rises.
- Lines idle, switches to 01, tx_line pulsed low 1 cycle every 15 cycles → pending = 1, s1/s0 stay 00. Stop pulsing → s1/s0 = 01 between 21 and 24 cycles after the last low sample.
- In PENDING (rx_line held low), switches return to 00 and stay → pending falls and FSM returns to ACTIVE; s1/s0 never leave 00; no switched pulse.
- Committed 01; switches to 11 with rx_line low; reset asserted 1 cycle mid-PENDING → s1/s0 = 00 and pending = 0 on the next edge. After rx_line is released, s1/s0 = 11 following re-debounce plus idle time.
- In PENDING with lines busy, switches go 01→10 (each held >8 cycles), then lines released → single switched pulse; s1/s0 go 00→10 directly and never pass through 01.

Source files
------------

// File: rtl/uart_sel_ctrl.sv
// rtl/uart_sel_ctrl.sv - UART port-select controller with debounce and idle-gated switch-over
//
// Ports:
//   clk       system clock, single domain
//   reset     synchronous active-high reset
//   sw0, sw1  raw select switches (asynchronous, bouncy)
//   tx_line   host transmit line, 1 = idle (asynchronous)
//   rx_line   selected-port receive line, 1 = idle (asynchronous)
//   s0, s1    committed select pair to the UART selector (registered)
//   pending   debounced selection differs from the committed one
//   switched  one-cycle pulse accompanying a new s1/s0 value
module uart_sel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int IDLE_CYCLES     = 28125
) (
  input  logic clk,
  input  logic reset,
  input  logic sw0,
  input  logic sw1,
  input  logic tx_line,
  input  logic rx_line,
  output logic s0,
  output logic s1,
  output logic pending,
  output logic switched
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWITCH  = 2'd2
  } state_t;

  logic [1:0]        sw_meta_q, sw_sync_q;
  logic [1:0]        line_meta_q, line_sync_q;
  logic [1:0]        cand_q;
  logic [DB_W-1:0]   db_cnt_q;
  logic [1:0]        deb_q;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic              line_idle;
  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic              switched_q, switched_d;

  // Two-flop synchronizers; lines reset to idle so a reset does not look like traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q   <= 2'b00;
      sw_sync_q   <= 2'b00;
      line_meta_q <= 2'b11;
      line_sync_q <= 2'b11;
    end else begin
      sw_meta_q   <= {sw1, sw0};
      sw_sync_q   <= sw_meta_q;
      line_meta_q <= {tx_line, rx_line};
      line_sync_q <= line_meta_q;
    end
  end

  // Debounce: any difference from the candidate (either bit) restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q   <= 2'b00;
      db_cnt_q <= '0;
      deb_q    <= 2'b00;
    end else begin
      if (sw_sync_q != cand_q) begin
        cand_q   <= sw_sync_q;
        db_cnt_q <= '0;
      end else if (db_cnt_q != DB_MAX) begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
      if (db_cnt_q == DB_MAX) begin
        deb_q <= cand_q;
      end
    end
  end

  // Idle monitor. Only a clean 1 on both lines counts as idle. The count also
  // restarts on a commit, so consecutive switch-overs are a full frame apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_q <= '0;
    end else if (line_sync_q != 2'b11 || state_q == ST_SWITCH) begin
      idle_cnt_q <= '0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  assign line_idle = (idle_cnt_q == IDLE_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ACTIVE;
      sel_q      <= 2'b00;
      switched_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      switched_q <= switched_d;
    end
  end

  // SWITCH commits whatever is debounced at that moment, so a change made
  // while waiting for idle is honoured without an intermediate value.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    switched_d = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (deb_q != sel_q) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (deb_q == sel_q) state_d = ST_ACTIVE;
        else if (line_idle) state_d = ST_SWITCH;
      end
      ST_SWITCH: begin
        sel_d      = deb_q;
        switched_d = 1'b1;
        state_d    = ST_ACTIVE;
      end
      default: begin
        state_d = ST_ACTIVE;
      end
    endcase
  end

  assign s0       = sel_q[0];
  assign s1       = sel_q[1];
  assign pending  = (state_q != ST_ACTIVE);
  assign switched = switched_q;

endmodule

// File: tb/tb_uart_sel_ctrl.sv
// tb/tb_uart_sel_ctrl.sv - scoreboard testbench for uart_sel_ctrl
module tb_uart_sel_ctrl;

  logic clk = 1'b0;
  logic reset, sw0, sw1, tx_line, rx_line;
  logic s0, s1, pending, switched;

  int total = 0;
  int bad   = 0;
  int sw_count = 0;
  logic [1:0] exp_q[$];
  logic prev_switched = 1'b0;

  uart_sel_ctrl #(.DEBOUNCE_CYCLES(8), .IDLE_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .sw0(sw0), .sw1(sw1),
    .tx_line(tx_line), .rx_line(rx_line),
    .s0(s0), .s1(s1), .pending(pending), .switched(switched)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Monitor: every switched pulse pops the next expected committed value.
  always @(negedge clk) begin
    if (switched === 1'b1) begin
      sw_count++;
      if (prev_switched) begin
        total++;
        bad++;
        $display("FAIL switched_width: got 2+ cycles expected 1");
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_switch: got %0d expected none", {s1, s0});
      end else begin
        chk("switch_value", {30'd0, s1, s0}, {30'd0, exp_q.pop_front()});
      end
    end
    prev_switched = (switched === 1'b1);
  end

  initial begin
    int n, pend_at, sel_at, viol, base;
    reset = 1'b1; sw0 = 1'b0; sw1 = 1'b0; tx_line = 1'b1; rx_line = 1'b1;
    step(2);
    reset = 1'b0;
    chk("reset_sel", {s1, s0}, 2'b00);
    chk("reset_pending", pending, 1'b0);
    chk("reset_switched", switched, 1'b0);
    step(25);

    // T1: select 10 with lines long idle
    base = sw_count;
    exp_q.push_back(2'b10);
    sw1 = 1'b1; sw0 = 1'b0;
    pend_at = 0; sel_at = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (pending && pend_at == 0) pend_at = i;
      if ({s1, s0} == 2'b10) begin sel_at = i; break; end
    end
    chk_range("t1_pending_latency", pend_at, 10, 13);
    chk_range("t1_sel_latency", sel_at, 12, 17);
    step(2);
    chk("t1_pending_after", pending, 1'b0);
    chk("t1_switch_count", sw_count - base, 1);

    // T2: bouncing sw0 never accepted
    sw1 = 1'b0; sw0 = 1'b0;
    do_reset();
    step(25);
    base = sw_count; viol = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) sw0 = ~sw0;
      step();
      if (pending || {s1, s0} != 2'b00) viol++;
    end
    sw0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pending || {s1, s0} != 2'b00) viol++;
    end
    chk("t2_bounce_violations", viol, 0);
    chk("t2_switch_count", sw_count - base, 0);

    // T3: tx pulses every 15 cycles hold the request pending
    do_reset();
    step(25);
    exp_q.push_back(2'b01);
    sw0 = 1'b1; viol = 0;
    for (int p = 0; p < 4; p++) begin
      tx_line = 1'b0; step();
      tx_line = 1'b1;
      for (int i = 0; i < 14; i++) begin
        step();
        if ({s1, s0} != 2'b00) viol++;
      end
    end
    chk("t3_held_sel", viol, 0);
    chk("t3_pending_held", pending, 1'b1);
    tx_line = 1'b0; step();
    tx_line = 1'b1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if ({s1, s0} == 2'b01) begin n = i; break; end
    end
    chk_range("t3_release_latency", n, 21, 24);

    // T4: user reverts while pending
    sw0 = 1'b0;
    do_reset();
    step(25);
    base = sw_count;
    rx_line = 1'b0;
    sw0 = 1'b1;
    n = 0;
    for (int i = 1; i <= 30; i++) begin step(); if (pending) begin n = i; break; end end
    chk_range("t4_pending_rise", n, 1, 30);
    sw0 = 1'b0;
    n = 0;
    for (int i = 1; i <= 30; i++) begin step(); if (!pending) begin n = i; break; end end
    chk_range("t4_pending_fall", n, 1, 30);
    rx_line = 1'b1;
    step(30);
    chk("t4_sel", {s1, s0}, 2'b00);
    chk("t4_switch_count", sw_count - base, 0);

    // T5: reset in the middle of PENDING, then full rerun
    exp_q.push_back(2'b01);
    sw0 = 1'b1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin step(); if ({s1, s0} == 2'b01) begin n = i; break; end end
    chk_range("t5_commit01", n, 1, 40);
    rx_line = 1'b0;
    sw1 = 1'b1;
    n = 0;
    for (int i = 1; i <= 30; i++) begin step(); if (pending) begin n = i; break; end end
    chk_range("t5_pending_rise", n, 1, 30);
    do_reset();
    chk("t5_reset_sel", {s1, s0}, 2'b00);
    chk("t5_reset_pending", pending, 1'b0);
    step(5);
    exp_q.push_back(2'b11);
    rx_line = 1'b1;
    n = 0;
    for (int i = 1; i <= 80; i++) begin step(); if ({s1, s0} == 2'b11) begin n = i; break; end end
    chk_range("t5_rerun_latency", n, 20, 30);

    // T6: 01 then 10 while busy; commit goes straight to 10
    sw1 = 1'b0; sw0 = 1'b0; rx_line = 1'b0;
    do_reset();
    base = sw_count;
    sw0 = 1'b1;
    step(15);
    chk("t6_pending_01", pending, 1'b1);
    sw0 = 1'b0; sw1 = 1'b1;
    step(15);
    chk("t6_pending_10", pending, 1'b1);
    chk("t6_sel_busy", {s1, s0}, 2'b00);
    exp_q.push_back(2'b10);
    rx_line = 1'b1;
    viol = 0; n = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if ({s1, s0} != 2'b00 && {s1, s0} != 2'b10) viol++;
      if ({s1, s0} == 2'b10) begin n = i; break; end
    end
    chk("t6_no_intermediate", viol, 0);
    chk_range("t6_commit", n, 20, 30);
    step(3);
    chk("t6_switch_count", sw_count - base, 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
